// File: rtl/xor_cipher_pkg.sv
// Shared constants and keystream step function for the multi-lane cipher.
// Keystream widths up to KS_MAX bits are supported.
package xor_cipher_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_LFSR   = 1'b1;

  localparam int KS_MAX = 64;
  localparam logic [31:0] DEF_LFSR_TAPS = 32'h8020_0003;
  localparam int DEF_HB_W = 24;

  // ks and taps are zero-extended to KS_MAX; w is the live width.
  function automatic logic [KS_MAX-1:0] next_ks(
    input logic [KS_MAX-1:0] ks,
    input logic              mode,
    input logic [KS_MAX-1:0] taps,
    input int                w
  );
    logic [KS_MAX-1:0] r;
    r = ks >> 1;
    if (mode == MODE_LFSR) begin
      r = r ^ (ks[0] ? taps : '0);
    end else begin
      r = r | (KS_MAX'(ks[0]) << (w - 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/keystream_channel.sv
// One bit-serial cipher lane: keystream state plus registered XOR output.
// load has priority over advance for ks; dout always uses the old ks[0].
module keystream_channel
  import xor_cipher_pkg::*;
#(
  parameter int              KEY_W = 32,
  parameter logic [KEY_W-1:0] TAPS = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             load,
  input  logic             mode,
  input  logic [KEY_W-1:0] seed,
  input  logic             din,
  output logic             dout
);

  logic [KEY_W-1:0] ks;
  logic [KEY_W-1:0] ks_step;

  assign ks_step = KEY_W'(next_ks(
    KS_MAX'(ks), mode, KS_MAX'(TAPS), KEY_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks   <= '0;
      dout <= 1'b0;
    end else begin
      if (adv) begin
        dout <= din ^ ks[0];
      end
      if (load) begin
        ks <= seed;
      end else if (adv) begin
        ks <= ks_step;
      end
    end
  end

endmodule

// File: rtl/multi_lfsr_stream_cipher.sv
// N-lane XOR stream cipher with serial {mode,key} config chain.
// CIPHER_LFSR_EN enables the Galois LFSR keystream mode.
module multi_lfsr_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int               KEY_W     = 32,
  parameter int               CH        = 2,
  parameter logic [KEY_W-1:0] LFSR_TAPS = KEY_W'(DEF_LFSR_TAPS),
  parameter int               HB_W      = DEF_HB_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic          cfg_i,
  output logic          cfg_o,
  input  logic [CH-1:0] ch_en,
  input  logic [CH-1:0] sync,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic          ready,
  output logic [2:0]    heartbeat
);

  logic [KEY_W:0]   cfg_q;
  logic             cfg_en_q;
  logic             commit;
  logic             live;
  logic             mode;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] seed;
  logic [HB_W-1:0]  hb;

  assign key    = cfg_q[KEY_W-1:0];
  assign commit = cfg_en_q & ~cfg_en;
  assign live   = ready & ~cfg_en;
  assign cfg_o  = cfg_q[KEY_W];

`ifdef CIPHER_LFSR_EN
  assign mode = cfg_q[KEY_W];
  // An all-zero LFSR state never leaves zero, so seed it with 1.
  assign seed = (mode == MODE_LFSR && key == '0)
              ? KEY_W'(1) : key;
`else
  assign mode = MODE_ROTATE;
  assign seed = key;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      cfg_en_q <= 1'b0;
      ready    <= 1'b0;
      hb       <= '0;
    end else begin
      cfg_en_q <= cfg_en;
      hb       <= hb + 1'b1;
      if (cfg_en) begin
        cfg_q <= {cfg_q[KEY_W-1:0], cfg_i};
      end
      if (commit) begin
        ready <= 1'b1;
      end
    end
  end

  assign heartbeat = hb[HB_W-1 -: 3];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    keystream_channel #(
      .KEY_W (KEY_W),
      .TAPS  (LFSR_TAPS)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (ch_en[c] & live),
      .load  (commit | (sync[c] & live)),
      .mode  (mode),
      .seed  (seed),
      .din   (din[c]),
      .dout  (dout[c])
    );
  end

endmodule

// File: tb/tb_multi_lfsr_stream_cipher.sv
// Randomised bench for multi_lfsr_stream_cipher (KEY_W=8, CH=2, taps B8)
// against a cycle-level reference model of the cipher rules.
module tb_multi_lfsr_stream_cipher;

  localparam logic [7:0] TAPS = 8'hB8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_i = 1'b0;
  logic       cfg_o;
  logic [1:0] ch_en = '0;
  logic [1:0] sync = '0;
  logic [1:0] din = '0;
  logic [1:0] dout;
  logic       ready;
  logic [2:0] heartbeat;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  logic [7:0]  m_ks [2];
  logic        m_dout [2];
  logic [8:0]  m_cfg;
  logic        m_cfg_en_q;
  logic        m_ready;
  logic [23:0] m_hb;

  multi_lfsr_stream_cipher #(
    .KEY_W     (8),
    .CH        (2),
    .LFSR_TAPS (TAPS),
    .HB_W      (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_i     (cfg_i),
    .cfg_o     (cfg_o),
    .ch_en     (ch_en),
    .sync      (sync),
    .din       (din),
    .dout      (dout),
    .ready     (ready),
    .heartbeat (heartbeat)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_ks[c]   = 8'h00;
      m_dout[c] = 1'b0;
    end
    m_cfg      = '0;
    m_cfg_en_q = 1'b0;
    m_ready    = 1'b0;
    m_hb       = '0;
  endfunction

  function automatic logic eff_mode();
`ifdef CIPHER_LFSR_EN
    return m_cfg[8];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] m_seed();
    logic [7:0] k;
    k = m_cfg[7:0];
`ifdef CIPHER_LFSR_EN
    if (m_cfg[8] && k == 8'h00) k = 8'h01;
`endif
    return k;
  endfunction

  // rotate right, or Galois step, by plain arithmetic
  function automatic logic [7:0] m_next(logic [7:0] k, logic md);
    if (md) return (k >> 1) ^ ((k % 2 == 1) ? TAPS : 8'h00);
    return 8'((k >> 1) + (k % 2) * 128);
  endfunction

  function automatic logic [1:0] m_dvec();
    return {m_dout[1], m_dout[0]};
  endfunction

  task automatic tick();
    logic       commit, adv, ld, md;
    logic [7:0] sd;
    logic [7:0] nks [2];
    logic       nd [2];
    logic [8:0] ncfg;
    commit = m_cfg_en_q && !cfg_en;
    md = eff_mode();
    sd = m_seed();
    for (int c = 0; c < 2; c++) begin
      adv = ch_en[c] && m_ready && !cfg_en;
      ld  = commit || (sync[c] && m_ready && !cfg_en);
      nd[c]  = adv ? (din[c] ^ m_ks[c][0]) : m_dout[c];
      nks[c] = ld ? sd : (adv ? m_next(m_ks[c], md) : m_ks[c]);
    end
    ncfg = cfg_en ? {m_cfg[7:0], cfg_i} : m_cfg;
    @(posedge clk);
    if (rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_ks[c]   = nks[c];
        m_dout[c] = nd[c];
      end
      m_cfg      = ncfg;
      m_cfg_en_q = cfg_en;
      if (commit) m_ready = 1'b1;
      m_hb = m_hb + 24'd1;
    end
    #1;
  endtask

  task automatic shift_cfg(input logic [8:0] v);
    cfg_en = 1'b1;
    for (int i = 8; i >= 0; i--) begin
      cfg_i = v[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    nvec++;
    if (dout !== 2'b00) begin
      nerr++;
      $display("FAIL reset_dout got=%b want=00", dout);
    end
    nvec++;
    if (ready !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ready got=%b want=0", ready);
    end
    nvec++;
    if (cfg_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_cfg_o got=%b want=0", cfg_o);
    end
    nvec++;
    if (heartbeat !== 3'd0) begin
      nerr++;
      $display("FAIL reset_hb got=%0d want=0", heartbeat);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] key;
    key = 8'hA5;
    shift_cfg({1'b0, key});
    nvec++;
    if (ready !== 1'b1) begin
      nerr++;
      $display("FAIL rot_ready got=%b want=1", ready);
    end
    ch_en = 2'b11;
    din   = 2'b00;
    for (int i = 0; i < 16; i++) begin
      tick();
      nvec++;
      if (dout[0] !== key[i % 8]) begin
        nerr++;
        $display("FAIL rot_seq i=%0d got=%b want=%b",
                 i, dout[0], key[i % 8]);
      end
      nvec++;
      if (dout !== m_dvec() || heartbeat !== m_hb[23:21]) begin
        nerr++;
        $display("FAIL rot_model i=%0d got=%b/%0d want=%b/%0d",
                 i, dout, heartbeat, m_dvec(), m_hb[23:21]);
      end
    end
    ch_en = 2'b00;
  endtask

  task automatic test_lfsr();
    logic [4:0] expv;
`ifdef CIPHER_LFSR_EN
    expv = 5'b10001;
`else
    expv = 5'b10000;
`endif
    shift_cfg(9'h101);
    ch_en = 2'b11;
    din   = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (dout[0] !== expv[4 - i] || dout !== m_dvec()) begin
        nerr++;
        $display("FAIL lfsr_seq i=%0d got=%b want=%b model=%b",
                 i, dout[0], expv[4 - i], m_dvec());
      end
    end
    ch_en = 2'b00;
  endtask

  task automatic test_zero_key();
    logic pdin;
    int   gap;
    shift_cfg(9'h100);
    ch_en = 2'b11;
    gap   = 0;
    for (int i = 0; i < 300; i++) begin
      din  = 2'($urandom);
      pdin = din[0];
      tick();
      nvec++;
      if (dout !== m_dvec()) begin
        nerr++;
        $display("FAIL zkey_model i=%0d got=%b want=%b",
                 i, dout, m_dvec());
      end
      gap = ((dout[0] ^ pdin) == 1'b1) ? 0 : gap + 1;
`ifdef CIPHER_LFSR_EN
      if (gap > 8) begin
        nvec++;
        nerr++;
        $display("FAIL zkey_stuck i=%0d got=zero-run want=<=8", i);
        gap = 0;
      end
`else
      nvec++;
      if (dout[0] !== pdin) begin
        nerr++;
        $display("FAIL zkey_pass i=%0d got=%b want=%b",
                 i, dout[0], pdin);
      end
`endif
    end
    ch_en = 2'b00;
  endtask

  task automatic test_loopback();
    logic hist [$];
    shift_cfg(9'($urandom));
    for (int r = 0; r < 2; r++) begin
      hist.delete();
      ch_en = 2'b00;
      sync  = 2'b11;
      tick();
      sync = 2'b00;
      for (int t = 0; t < 40; t++) begin
        ch_en  = {(t > 0), 1'b1};
        din[0] = 1'($urandom);
        din[1] = dout[0];
        hist.push_back(din[0]);
        tick();
        if (t >= 1) begin
          nvec++;
          if (dout[1] !== hist[t - 1] || dout !== m_dvec()) begin
            nerr++;
            $display("FAIL loop r=%0d t=%0d got=%b want=%b",
                     r, t, dout[1], hist[t - 1]);
          end
        end
      end
    end
    ch_en = 2'b00;
  endtask

  task automatic test_chain();
    logic [8:0] bits;
    bits   = 9'b101100101;
    cfg_en = 1'b1;
    for (int i = 8; i >= 0; i--) begin
      cfg_i = bits[i];
      tick();
    end
    for (int j = 0; j < 9; j++) begin
      nvec++;
      if (cfg_o !== bits[8 - j] || cfg_o !== m_cfg[8]) begin
        nerr++;
        $display("FAIL chain j=%0d got=%b want=%b",
                 j, cfg_o, bits[8 - j]);
      end
      cfg_i = 1'b0;
      tick();
    end
    cfg_en = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [1:0] hold;
    shift_cfg(9'($urandom));
    ch_en = 2'b11;
    for (int i = 0; i < 10; i++) begin
      din = 2'($urandom);
      tick();
    end
    hold   = dout;
    cfg_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_i = 1'($urandom);
      din   = 2'($urandom);
      sync  = 2'($urandom);
      tick();
      nvec++;
      if (dout !== hold) begin
        nerr++;
        $display("FAIL stall i=%0d got=%b want=%b", i, dout, hold);
      end
    end
    sync = 2'b00;
    for (int p = 0; p < 2; p++) begin
      cfg_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
        din  = 2'($urandom);
        sync = (i == 6) ? 2'($urandom) : 2'b00;
        tick();
        nvec++;
        if (dout !== m_dvec()) begin
          nerr++;
          $display("FAIL after_stall p=%0d i=%0d got=%b want=%b",
                   p, i, dout, m_dvec());
        end
      end
      cfg_en = 1'b1;
      cfg_i  = 1'($urandom);
      tick();
    end
    cfg_en = 1'b0;
    tick();
    nvec++;
    if (ready !== 1'b1 || cfg_o !== m_cfg[8]) begin
      nerr++;
      $display("FAIL pulse_commit got=%b/%b want=1/%b",
               ready, cfg_o, m_cfg[8]);
    end
  endtask

  task automatic test_reset_mid();
    ch_en = 2'b11;
    din   = 2'b11;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    nvec++;
    if (dout !== 2'b00 || ready !== 1'b0) begin
      nerr++;
      $display("FAIL async_rst got=%b/%b want=00/0", dout, ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 2'($urandom);
      tick();
      nvec++;
      if (dout !== 2'b00 || ready !== 1'b0) begin
        nerr++;
        $display("FAIL post_rst i=%0d got=%b/%b want=00/0",
                 i, dout, ready);
      end
    end
    ch_en = 2'b00;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_rotate();
    test_lfsr();
    test_zero_key();
    test_loopback();
    test_chain();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
